compute_arbiter: RTL and testbench

COMPUTE_ARBITER -- requirements
Module: compute_arbiter

---
 rtl/accel_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/compute_arbiter.sv | 149 ++++++++++++++
 tb/tb_compute_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and constants for the compute arbiter slice.
// Unit IDs are 2 bits wide, which bounds the arbiter to four requesters.
package accel_pkg;

   localparam int NUM_UNITS_MAX       = 4;
   localparam int ARB_TIMEOUT_DEFAULT = 64;

   typedef logic [1:0] unit_id_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RELEASE
   } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// The search starts one past the last winner and returns the first set request bit.
module rr_priority_picker
   import accel_pkg::*;
#(
   parameter int NUM_UNITS = 4
) (
   input  logic [NUM_UNITS-1:0] req,
   input  logic [1:0]           last_winner,
   output logic                 valid,
   output logic [1:0]           winner
);

   localparam int IDX_W = $clog2(NUM_UNITS);

   always_comb begin : p_pick
      logic [IDX_W-1:0] w_idx;
      w_idx  = '0;
      valid  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NUM_UNITS; k++) begin
         w_idx = IDX_W'((int'(last_winner) + k) % NUM_UNITS);
         if (!valid && req[w_idx]) begin
            valid  = 1'b1;
            winner = unit_id_t'(w_idx);
         end
      end
   end

endmodule

// File: rtl/compute_arbiter.sv
// Round-robin arbiter granting one of NUM_UNITS requesters access to a shared compute unit.
// Define COMPUTE_ARB_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT_CYCLES) and timeout_err.
//
//   state   | meaning
//   IDLE    | no grant; waiting for a request while the compute unit is ready
//   ISSUE   | grant registered; cu_request strobed for one cycle
//   WAIT    | grant held; waiting for cu_done (or watchdog expiry)
//   RELEASE | unit_done/timeout_err pulse; grant cleared and winner remembered
module compute_arbiter
   import accel_pkg::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_UNITS-1:0] req,
   output logic [NUM_UNITS-1:0] gnt,
   output logic [NUM_UNITS-1:0] unit_done,
   output logic [1:0]           sel_id,
   output logic                 cu_request,
   output logic [1:0]           cu_unit_id,
   input  logic                 cu_ready,
   input  logic                 cu_done,
   output logic                 busy,
   output logic                 timeout_err
);

   if (NUM_UNITS < 2 || NUM_UNITS > NUM_UNITS_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("compute_arbiter: unsupported NUM_UNITS or TIMEOUT_CYCLES");
   end

   localparam logic [NUM_UNITS-1:0] W_ONE = {{(NUM_UNITS-1){1'b0}}, 1'b1};

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic [NUM_UNITS-1:0]   r_gnt;
   logic [NUM_UNITS-1:0]   w_gnt_nxt;
   logic [NUM_UNITS-1:0]   r_unit_done;
   logic [NUM_UNITS-1:0]   w_unit_done_nxt;
   unit_id_t               r_sel_id;
   unit_id_t               w_sel_id_nxt;
   unit_id_t               r_last_winner;
   unit_id_t               w_last_winner_nxt;
   logic                   w_pick_valid;
   unit_id_t               w_pick_id;
   logic                   w_wdog_expired;

   rr_priority_picker #(
      .NUM_UNITS (NUM_UNITS)
   ) u_picker (
      .req         (req),
      .last_winner (r_last_winner),
      .valid       (w_pick_valid),
      .winner      (w_pick_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_gnt         <= '0;
         r_unit_done   <= '0;
         r_sel_id      <= '0;
         r_last_winner <= unit_id_t'(NUM_UNITS - 1);
      end else begin
         r_state       <= w_state_nxt;
         r_gnt         <= w_gnt_nxt;
         r_unit_done   <= w_unit_done_nxt;
         r_sel_id      <= w_sel_id_nxt;
         r_last_winner <= w_last_winner_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_gnt_nxt         = r_gnt;
      w_unit_done_nxt   = '0;
      w_sel_id_nxt      = r_sel_id;
      w_last_winner_nxt = r_last_winner;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid && cu_ready) begin
               w_state_nxt  = ST_ISSUE;
               w_gnt_nxt    = W_ONE << w_pick_id;
               w_sel_id_nxt = w_pick_id;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // cu_done takes priority over a watchdog expiry in the same cycle
            if (cu_done) begin
               w_state_nxt     = ST_RELEASE;
               w_unit_done_nxt = W_ONE << r_sel_id;
            end else if (w_wdog_expired) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            w_state_nxt       = ST_IDLE;
            w_gnt_nxt         = '0;
            w_last_winner_nxt = r_sel_id;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

`ifdef COMPUTE_ARB_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout_err;

   // Loaded while issuing; reaches zero on the TIMEOUT_CYCLES-th WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_wdog_expired && !cu_done;
         if (r_state == ST_ISSUE) begin
            r_wdog <= WDOG_W'(TIMEOUT_CYCLES - 1);
         end else if (r_state == ST_WAIT && r_wdog != '0) begin
            r_wdog <= r_wdog - 1'b1;
         end else if (r_state != ST_WAIT) begin
            r_wdog <= '0;
         end
      end
   end

   assign w_wdog_expired = (r_state == ST_WAIT) && (r_wdog == '0);
   assign timeout_err    = r_timeout_err;
`else
   assign w_wdog_expired = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   assign gnt        = r_gnt;
   assign unit_done  = r_unit_done;
   assign sel_id     = r_sel_id;
   assign cu_unit_id = r_sel_id;
   assign cu_request = (r_state == ST_ISSUE);
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_compute_arbiter.sv
// Directed self-checking bench for compute_arbiter (4 units, TIMEOUT_CYCLES=8).
// Timeout scenarios run only when COMPUTE_ARB_TIMEOUT_EN is defined.
module tb_compute_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0;
   logic       cu_ready = 1'b0;
   logic       cu_done = 1'b0;
   logic [3:0] gnt;
   logic [3:0] unit_done;
   logic [1:0] sel_id;
   logic       cu_request;
   logic [1:0] cu_unit_id;
   logic       busy;
   logic       timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] g, ud, ud_a;
   logic [1:0] uid;
   logic       creq2, tmo, busy_a;
   int         waited;

   compute_arbiter #(
      .NUM_UNITS      (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .unit_done   (unit_done),
      .sel_id      (sel_id),
      .cu_request  (cu_request),
      .cu_unit_id  (cu_unit_id),
      .cu_ready    (cu_ready),
      .cu_done     (cu_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_time_limit: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   task automatic apply_reset();
      rst_n    = 1'b0;
      req      = 4'b0;
      cu_ready = 1'b0;
      cu_done  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs one operation: waits for cu_request, returns cu_done lat cycles later,
   // and reports what was observed. Ends at the negedge of the IDLE cycle after RELEASE.
   task automatic do_op(input int lat, input bit drop,
                        output logic [3:0] o_g, output logic [1:0] o_uid,
                        output logic o_creq2, output logic [3:0] o_ud,
                        output logic [3:0] o_ud_after, output logic o_tmo,
                        output logic o_busy_after, output int o_waited);
      o_tmo = 1'b0;
      o_waited = 21;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         o_tmo |= timeout_err;
         if (cu_request) begin
            o_waited = i;
            break;
         end
      end
      o_g   = gnt;
      o_uid = cu_unit_id;
      @(negedge clk);
      o_creq2 = cu_request;
      o_tmo  |= timeout_err;
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         o_tmo |= timeout_err;
      end
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      o_ud   = unit_done;
      o_tmo |= timeout_err;
      if (drop) req = req & ~unit_done;
      @(negedge clk);
      o_busy_after = busy;
      o_ud_after   = unit_done;
      o_tmo       |= timeout_err;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      req      = 4'b1111;
      cu_ready = 1'b1;
      cu_done  = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({gnt, unit_done, sel_id, cu_request, cu_unit_id, busy, timeout_err} !== 15'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b done=%b sel=%0d creq=%b uid=%0d busy=%b tmo=%b, want all 0",
                  gnt, unit_done, sel_id, cu_request, cu_unit_id, busy, timeout_err);
      end
      apply_reset();
      n_tests++;
      if (busy !== 1'b0 || gnt !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_idle_after_release: busy=%b gnt=%b, want 0/0000", busy, gnt);
      end
   endtask

   task automatic test_single();
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b0100;
      do_op(5, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (waited !== 1) begin
         n_fail++; $display("FAIL single_issue_latency: got %0d cycles want 1", waited);
      end
      n_tests++;
      if (g !== 4'b0100) begin
         n_fail++; $display("FAIL single_gnt: got %b want 0100", g);
      end
      n_tests++;
      if (uid !== 2'd2) begin
         n_fail++; $display("FAIL single_cu_unit_id: got %0d want 2", uid);
      end
      n_tests++;
      if (creq2 !== 1'b0) begin
         n_fail++; $display("FAIL single_cu_request_one_cycle: second cycle got %b want 0", creq2);
      end
      n_tests++;
      if (ud !== 4'b0100) begin
         n_fail++; $display("FAIL single_unit_done: got %b want 0100", ud);
      end
      n_tests++;
      if (ud_a !== 4'b0000 || busy_a !== 1'b0 || gnt !== 4'b0000) begin
         n_fail++; $display("FAIL single_after: done=%b busy=%b gnt=%b want 0000/0/0000", ud_a, busy_a, gnt);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         do_op(2, 1'b0, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
         n_tests++;
         if (g !== exp_g[i] || ud !== exp_g[i] || waited !== 1) begin
            n_fail++;
            $display("FAIL fairness_grant%0d: gnt=%b done=%b wait=%0d want gnt=done=%b wait=1",
                     i, g, ud, waited, exp_g[i]);
         end
         n_tests++;
         if (uid !== 2'(i % 4)) begin
            n_fail++; $display("FAIL fairness_uid%0d: got %0d want %0d", i, uid, i % 4);
         end
      end
      req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad;
      apply_reset();
      req      = 4'b0001;
      cu_ready = 1'b0;
      bad      = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (gnt !== 4'b0 || cu_request !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, want 0", bad);
      end
      cu_ready = 1'b1;
      do_op(3, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (waited !== 1 || g !== 4'b0001 || ud !== 4'b0001) begin
         n_fail++;
         $display("FAIL backpressure_release: wait=%0d gnt=%b done=%b want 1/0001/0001", waited, g, ud);
      end
   endtask

   task automatic test_spurious_done();
      apply_reset();
      req      = 4'b0001;
      cu_ready = 1'b0;
      @(negedge clk);
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      n_tests++;
      if (unit_done !== 4'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL done_in_idle: done=%b busy=%b want 0000/0", unit_done, busy);
      end
      cu_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (cu_request !== 1'b1) begin
         n_fail++; $display("FAIL issue_after_ready: cu_request=%b want 1", cu_request);
      end
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      req     = 4'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || unit_done !== 4'b0 || gnt !== 4'b0001 || cu_request !== 1'b0) begin
         n_fail++;
         $display("FAIL done_in_issue_ignored: busy=%b done=%b gnt=%b creq=%b want 1/0000/0001/0",
                  busy, unit_done, gnt, cu_request);
      end
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      n_tests++;
      if (unit_done !== 4'b0001) begin
         n_fail++; $display("FAIL done_after_req_drop: got %b want 0001", unit_done);
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || gnt !== 4'b0) begin
         n_fail++; $display("FAIL release_to_idle: busy=%b gnt=%b want 0/0000", busy, gnt);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [3:0] ud_seen;
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b0001;
      do_op(1, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (g !== 4'b0001 || ud !== 4'b0001) begin
         n_fail++; $display("FAIL rmw_first_op: gnt=%b done=%b want 0001/0001", g, ud);
      end
      req = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cu_request) break;
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || gnt !== 4'b0010) begin
         n_fail++; $display("FAIL rmw_in_wait: busy=%b gnt=%b want 1/0010", busy, gnt);
      end
      rst_n   = 1'b0;
      cu_done = 1'b1;
      #1;
      n_tests++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rmw_async_reset: gnt=%b busy=%b want 0000/0", gnt, busy);
      end
      ud_seen = 4'b0;
      repeat (2) begin
         @(negedge clk);
         ud_seen |= unit_done;
      end
      n_tests++;
      if ({gnt, unit_done, sel_id, cu_request, cu_unit_id, busy, timeout_err} !== 15'b0) begin
         n_fail++;
         $display("FAIL rmw_reset_outputs: gnt=%b done=%b sel=%0d creq=%b uid=%0d busy=%b tmo=%b want all 0",
                  gnt, unit_done, sel_id, cu_request, cu_unit_id, busy, timeout_err);
      end
      rst_n   = 1'b1;
      cu_done = 1'b0;
      req     = 4'b0011;
      do_op(2, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (g !== 4'b0001 || ud !== 4'b0001 || ud_seen !== 4'b0) begin
         n_fail++;
         $display("FAIL rmw_next_grant: gnt=%b done=%b done_in_reset=%b want 0001/0001/0000", g, ud, ud_seen);
      end
      do_op(2, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (g !== 4'b0010 || ud !== 4'b0010) begin
         n_fail++; $display("FAIL rmw_pending_kept: gnt=%b done=%b want 0010/0010", g, ud);
      end
   endtask

`ifdef COMPUTE_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int first_tmo, tmo_cnt;
      logic [3:0] ud_any;
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cu_request) break;
      end
      first_tmo = -1;
      tmo_cnt   = 0;
      ud_any    = 4'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ud_any |= unit_done;
         if (timeout_err) begin
            tmo_cnt++;
            if (first_tmo < 0) first_tmo = k;
            req = 4'b0;
         end
      end
      n_tests++;
      if (first_tmo !== 9 || tmo_cnt !== 1) begin
         n_fail++;
         $display("FAIL timeout_pulse: first at ISSUE+%0d count %0d, want ISSUE+9 count 1", first_tmo, tmo_cnt);
      end
      n_tests++;
      if (ud_any !== 4'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_no_done: done=%b busy=%b want 0000/0", ud_any, busy);
      end
   endtask

   task automatic test_done_wins();
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b0001;
      do_op(8, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (ud !== 4'b0001 || tmo !== 1'b0) begin
         n_fail++; $display("FAIL done_wins: done=%b timeout_seen=%b want 0001/0", ud, tmo);
      end
   endtask
`else
   task automatic test_no_timeout();
      apply_reset();
      cu_ready = 1'b1;
      req      = 4'b0001;
      do_op(30, 1'b1, g, uid, creq2, ud, ud_a, tmo, busy_a, waited);
      n_tests++;
      if (ud !== 4'b0001 || tmo !== 1'b0) begin
         n_fail++; $display("FAIL long_wait: done=%b timeout_seen=%b want 0001/0", ud, tmo);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_spurious_done();
      test_reset_mid_wait();
`ifdef COMPUTE_ARB_TIMEOUT_EN
      test_timeout();
      test_done_wins();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
